// File: rtl/data_mem_responder.sv
//============================================================================
// data_mem_responder : multi-cycle byte-addressed data memory, valid/ready in
// Rev 1.0
//============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int WIDTH         = 32,
  parameter int MEM_ADDR_BITS = 12,
  parameter int LATENCY       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [3:0]       req_wstrb,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int         DEPTH    = 1 << MEM_ADDR_BITS;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  // Backing store has no reset; it powers up cleared.
  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  logic [MEM_ADDR_BITS-3:0] w_word_idx;
  logic                     w_accept;
  logic                     w_err;
  logic                     w_access;
  logic                     w_commit;
  logic [WIDTH-1:0]         w_rword;

  assign req_ready  = (state_q != ST_WAIT);
  assign w_accept   = req_valid && req_ready;
  assign w_word_idx = addr_q[MEM_ADDR_BITS-1:2];
  assign w_err      = (addr_q[1:0] != 2'b00) || (addr_q[WIDTH-1:MEM_ADDR_BITS] != '0);
  assign w_access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign w_commit   = w_access && we_q && !w_err;

  always_comb begin
    w_rword = '0;
    for (int i = 0; i < 4; i++) begin
      w_rword[8*i +: 8] = mem_q[{w_word_idx, 2'(i)}];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (w_accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          err_d        = w_err;
          if (!w_err && !we_q) begin
            rdata_d = w_rword;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Stores land only on the access edge, so a reset during WAIT drops them.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[{w_word_idx, 2'(i)}] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: four responders at latencies 1, 2, 3 and 15 against a byte-array model.
`default_nettype none

module tb_data_mem_responder;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [4];
  logic        req_ready  [4];
  logic        req_we     [4];
  logic [31:0] req_addr   [4];
  logic [31:0] req_wdata  [4];
  logic [3:0]  req_wstrb  [4];
  logic        resp_valid [4];
  logic [31:0] resp_rdata [4];
  logic        resp_err   [4];

  int          cyc    = 0;
  int          checks = 0;
  int          passes = 0;
  int          last_acc [4];
  logic [7:0]  mdl [4][4096];
  exp_t        sbq [$];
  exp_t        mon_e;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(
      .WIDTH        (32),
      .MEM_ADDR_BITS(12),
      .LATENCY      (lat_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: word-aligned, in-range accesses hit the byte array; anything else errors.
  task automatic model_push(input int s, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] st, input int due);
    exp_t e;
    int   base;
    e.inst  = s;
    e.due   = due;
    e.err   = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    e.rdata = 32'h0;
    base    = int'(a[11:0]);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (st[i]) mdl[s][base + i] = d[8*i +: 8];
      end else begin
        e.rdata = {mdl[s][base + 3], mdl[s][base + 2], mdl[s][base + 1], mdl[s][base]};
      end
    end
    sbq.push_back(e);
  endtask

  // Presents a request and returns just after the edge that accepts it (valid left high).
  task automatic issue(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic push, output int acc);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = a;
    req_wdata[s] = d;
    req_wstrb[s] = st;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready[s]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 32'(req_ready[s]), 32'h1);
    end else begin
      last_acc[s] = acc;
      if (push) model_push(s, we, a, d, st, acc + lat_of(s));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int s, input int n);
    req_valid[s] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 4; s++) begin
        if (resp_valid[s]) begin
          if (sbq.size() == 0) begin
            chk("resp_unexpected", 32'(resp_valid[s]), 32'h0);
          end else begin
            mon_e = sbq.pop_front();
            chk("resp_inst",  32'(s),             32'(mon_e.inst));
            chk("resp_cycle", 32'(cyc),           32'(mon_e.due));
            chk("resp_rdata", resp_rdata[s],      mon_e.rdata);
            chk("resp_err",   32'(resp_err[s]),   32'(mon_e.err));
          end
        end
        if (cyc >= last_acc[s] && cyc < last_acc[s] + lat_of(s))
          chk("ready_in_wait", 32'(req_ready[s]), 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2, a3, r;
    logic [31:0] ra;
    for (int s = 0; s < 4; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 32'h0;
      req_wdata[s] = 32'h0;
      req_wstrb[s] = 4'h0;
      last_acc[s]  = -1000;
      for (int b = 0; b < 4096; b++) mdl[s][b] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      chk("rst_req_ready",  32'(req_ready[s]),  32'h1);
      chk("rst_resp_valid", 32'(resp_valid[s]), 32'h0);
      chk("rst_resp_rdata", resp_rdata[s],      32'h0);
      chk("rst_resp_err",   32'(resp_err[s]),   32'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed: basic, strobes, errors and boundary on the LATENCY=2 instance.
    issue(1, 1'b1, 32'h010, 32'hDEADBEEF, 4'b1111, 1'b1, a0); idle(1, 2);
    issue(1, 1'b0, 32'h010, 32'h0,        4'b0000, 1'b1, a0); idle(1, 2);
    issue(1, 1'b1, 32'h020, 32'h11223344, 4'b0101, 1'b1, a0); idle(1, 2);
    issue(1, 1'b0, 32'h020, 32'h0,        4'b1111, 1'b1, a0); idle(1, 2);
    issue(1, 1'b0, 32'h013, 32'h0,        4'b1111, 1'b1, a0); idle(1, 1);
    issue(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1'b1, a0); idle(1, 1);
    issue(1, 1'b1, 32'h0FC, 32'hA1B2C3D4, 4'b0000, 1'b1, a0); idle(1, 1);
    issue(1, 1'b0, 32'hFFC, 32'h0,        4'b0000, 1'b1, a0); idle(1, 1);
    issue(1, 1'b0, 32'h000, 32'h0,        4'b0000, 1'b1, a0); idle(1, 0);
    drain();

    // Back-to-back with valid held high on the LATENCY=1 instance.
    issue(0, 1'b1, 32'h100, 32'hA5A51234, 4'b1111, 1'b1, a0);
    issue(0, 1'b0, 32'h100, 32'h0,        4'b0000, 1'b1, a1);
    issue(0, 1'b1, 32'h104, 32'h0BADF00D, 4'b1100, 1'b1, a2);
    issue(0, 1'b0, 32'h104, 32'h0,        4'b0000, 1'b1, a3);
    idle(0, 0);
    chk("b2b_spacing0", 32'(a1 - a0), 32'(lat_of(0) + 1));
    chk("b2b_spacing1", 32'(a2 - a1), 32'(lat_of(0) + 1));
    chk("b2b_spacing2", 32'(a3 - a2), 32'(lat_of(0) + 1));
    drain();

    // Reset during WAIT on the LATENCY=3 instance: the store must vanish.
    issue(2, 1'b1, 32'h040, 32'hCAFEF00D, 4'b1111, 1'b0, a0);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready",  32'(req_ready[2]),  32'h1);
    chk("midrst_resp_valid", 32'(resp_valid[2]), 32'h0);
    chk("midrst_resp_rdata", resp_rdata[2],      32'h0);
    chk("midrst_resp_err",   32'(resp_err[2]),   32'h0);
    last_acc[2] = -1000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2, 1'b0, 32'h040, 32'h0, 4'b1111, 1'b1, a0); idle(2, 0);
    drain();

    // Maximum latency on the LATENCY=15 instance.
    issue(3, 1'b1, 32'h008, 32'h5EED0001, 4'b1111, 1'b1, a0); idle(3, 0);
    issue(3, 1'b0, 32'h008, 32'h0,        4'b0000, 1'b1, a0); idle(3, 0);
    drain();

    // Randomized traffic on every instance.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < ((s == 3) ? 6 : 30); k++) begin
        r = int'($urandom_range(0, 9));
        case (r)
          0: begin
            ra = 32'($urandom_range(0, 4095));
            ra[1:0] = 2'($urandom_range(1, 3));
          end
          1:       ra = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
          2:       ra = 32'hFFC;
          default: ra = 32'($urandom_range(0, 63)) << 2;
        endcase
        issue(s, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b1, a0);
        if ($urandom_range(0, 1) == 1) idle(s, int'($urandom_range(0, 3)));
      end
      idle(s, 0);
      drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
